// File: rtl/elastic_buffer_pkg.sv
// Shared constants for the PHY receive elastic buffer.
// SKP symbols (both disparities) and default geometry.
package elastic_buffer_pkg;

  localparam int DEF_DATA_WIDTH   = 10;
  localparam int DEF_BUFFER_DEPTH = 16;
  localparam int DEF_HIGH_WM      = 12;
  localparam int DEF_LOW_WM       = 4;

  localparam logic [9:0] SKP_RDN = 10'b0011111001;
  localparam logic [9:0] SKP_RDP = 10'b1100000110;

endpackage

// File: rtl/binToGray.sv
// Binary to Gray code converter.
// Ports: bin (binary in), gray (Gray out), width WIDTH.
module binToGray #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/grayToBin.sv
// Gray code to binary converter.
// Ports: gray (Gray in), bin (binary out), width WIDTH.
module grayToBin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/write_pointer_control.sv
// Elastic buffer write-side pointer control, recovered-clock domain.
// Ports: write_clk, rst_n (sync, active low), data_in, data_valid,
// gray_read_pointer in; write_enable, write_address,
// gray_write_pointer, full, skp_removed, add_req, overflow out;
// ovf_count when ELASTIC_OVF_CNT_EN is defined.
module write_pointer_control
  import elastic_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH,
  parameter int HIGH_WM      = DEF_HIGH_WM,
  parameter int LOW_WM       = DEF_LOW_WM,
  localparam int ADDR_W      = $clog2(BUFFER_DEPTH),
  localparam int PW          = ADDR_W + 1
) (
  input  logic                  write_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic [PW-1:0]         gray_read_pointer,
  output logic                  write_enable,
  output logic [PW-1:0]         write_address,
  output logic [PW-1:0]         gray_write_pointer,
  output logic                  full,
  output logic                  skp_removed,
  output logic                  add_req,
`ifdef ELASTIC_OVF_CNT_EN
  output logic                  overflow,
  output logic [7:0]            ovf_count
`else
  output logic                  overflow
`endif
);

  localparam logic [PW-1:0] DEPTH_P = PW'(BUFFER_DEPTH);
  localparam logic [PW-1:0] HIGH_P  = PW'(HIGH_WM);
  localparam logic [PW-1:0] LOW_P   = PW'(LOW_WM);
  localparam logic [PW-1:0] MID_P   = PW'((LOW_WM + HIGH_WM) / 2);

  logic [PW-1:0] sync1;
  logic [PW-1:0] sync2;
  logic [PW-1:0] rd_bin_s;
  logic [PW-1:0] occ;
  logic [PW-1:0] wa_next;
  logic [PW-1:0] occ_next;
  logic          is_skp;
  logic          skp_prev;
  logic          del;

  grayToBin #(.WIDTH(PW)) u_g2b (
    .gray (sync2),
    .bin  (rd_bin_s)
  );

  binToGray #(.WIDTH(PW)) u_b2g (
    .bin  (write_address),
    .gray (gray_write_pointer)
  );

  assign is_skp = (data_in == DATA_WIDTH'(SKP_RDN))
               || (data_in == DATA_WIDTH'(SKP_RDP));

  // Modulo subtraction; the extra MSB keeps full distinct from empty.
  assign occ = write_address - rd_bin_s;

  // Combinational strobes are gated so they stay low during reset.
  assign del = rst_n & data_valid & is_skp & skp_prev
             & (occ >= HIGH_P);

  assign write_enable = rst_n & data_valid & ~del & ~full;
  assign overflow     = rst_n & data_valid & ~del & full;
  assign skp_removed  = del;

  assign wa_next  = write_address + PW'(write_enable);
  assign occ_next = wa_next - rd_bin_s;

  always_ff @(posedge write_clk) begin
    if (!rst_n) begin
      sync1         <= '0;
      sync2         <= '0;
      write_address <= '0;
      full          <= 1'b0;
      add_req       <= 1'b0;
      skp_prev      <= 1'b0;
    end else begin
      sync1         <= gray_read_pointer;
      sync2         <= sync1;
      write_address <= wa_next;
      full          <= (occ_next == DEPTH_P);
      if (occ_next <= LOW_P) begin
        add_req <= 1'b1;
      end else if (occ_next >= MID_P) begin
        add_req <= 1'b0;
      end
      // A SKP dropped on overflow leaves the ordered-set tracking alone.
      if (data_valid) begin
        if (!is_skp) begin
          skp_prev <= 1'b0;
        end else if (write_enable || del) begin
          skp_prev <= 1'b1;
        end
      end
    end
  end

`ifdef ELASTIC_OVF_CNT_EN
  always_ff @(posedge write_clk) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (overflow && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_write_pointer_control.sv
// Randomized scoreboard bench for write_pointer_control.
// Integer occupancy model; checks ovf_count if ELASTIC_OVF_CNT_EN.
module tb_write_pointer_control;
  import elastic_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int HIGH  = 12;
  localparam int LOW   = 4;
  localparam int MID   = 8;

  logic       write_clk = 1'b0;
  logic       rst_n;
  logic [9:0] data_in;
  logic       data_valid;
  logic [4:0] gray_read_pointer;
  logic       write_enable;
  logic [4:0] write_address;
  logic [4:0] gray_write_pointer;
  logic       full;
  logic       skp_removed;
  logic       add_req;
  logic       overflow;
`ifdef ELASTIC_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif

  write_pointer_control dut (
    .write_clk          (write_clk),
    .rst_n              (rst_n),
    .data_in            (data_in),
    .data_valid         (data_valid),
    .gray_read_pointer  (gray_read_pointer),
    .write_enable       (write_enable),
    .write_address      (write_address),
    .gray_write_pointer (gray_write_pointer),
    .full               (full),
    .skp_removed        (skp_removed),
    .add_req            (add_req),
`ifdef ELASTIC_OVF_CNT_EN
    .overflow           (overflow),
    .ovf_count          (ovf_count)
`else
    .overflow           (overflow)
`endif
  );

  always #5 write_clk = ~write_clk;

  typedef struct {
    bit       we;
    bit       sr;
    bit       ov;
    bit       full;
    bit       add;
    bit [4:0] wa;
    bit [4:0] gwp;
    int       cnt;
  } exp_t;

  exp_t q[$];
  int pass_n  = 0;
  int total_n = 0;

  // Reference state: unbounded symbol counts, not wrapped pointers.
  int wr_total = 0;
  int rd_int   = 0;
  int h1       = 0;
  int h2       = 0;
  int ovf_m    = 0;
  bit full_m   = 0;
  bit add_m    = 0;
  bit sp_m     = 0;

  task automatic check(input string name, input int act,
                       input int req);
    total_n++;
    if (act == req) pass_n++;
    else $display("FAIL %s: got %0d, required %0d @%0t",
                  name, act, req, $time);
  endtask

  function automatic bit [4:0] gray5(input int v);
    bit [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] v;
    v = 10'($urandom);
    if (v == SKP_RDN || v == SKP_RDP) v[0] = ~v[0];
    return v;
  endfunction

  task automatic step(input bit rst, input bit dv,
                      input logic [9:0] sym);
    exp_t e;
    int   occ;
    int   occn;
    bit   skp;
    bit   del;
    @(negedge write_clk);
    rst_n             = !rst;
    data_valid        = dv;
    data_in           = sym;
    gray_read_pointer = gray5(rd_int);
    e.we = 0;
    e.sr = 0;
    e.ov = 0;
    if (rst) begin
      wr_total = 0;
      h1       = 0;
      h2       = 0;
      full_m   = 0;
      add_m    = 0;
      sp_m     = 0;
      ovf_m    = 0;
    end else begin
      skp  = (sym == SKP_RDN) || (sym == SKP_RDP);
      occ  = wr_total - h2;
      del  = dv && skp && sp_m && (occ >= HIGH);
      e.we = dv && !del && !full_m;
      e.ov = dv && !del && full_m;
      e.sr = del;
      if (e.we) wr_total++;
      occn   = wr_total - h2;
      full_m = (occn == DEPTH);
      if (occn <= LOW) add_m = 1;
      else if (occn >= MID) add_m = 0;
      if (dv) begin
        if (!skp) sp_m = 0;
        else if (e.we || del) sp_m = 1;
      end
      if (e.ov && ovf_m < 255) ovf_m++;
      h2 = h1;
      h1 = rd_int;
    end
    e.wa   = 5'(wr_total % 32);
    e.gwp  = gray5(wr_total);
    e.full = full_m;
    e.add  = add_m;
    e.cnt  = ovf_m;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rd_int = 0;
    step(1, 0, 10'd0);
  endtask

  task automatic writes(input int n);
    for (int i = 0; i < n; i++) step(0, 1, rand_data());
  endtask

  // Monitor: combinational strobes mid-cycle, state after the edge.
  initial begin : monitor
    exp_t e;
    bit [4:0] prev_g;
    prev_g = 0;
    forever begin
      @(negedge write_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("write_enable", int'(write_enable), int'(e.we));
        check("skp_removed", int'(skp_removed), int'(e.sr));
        check("overflow", int'(overflow), int'(e.ov));
        @(posedge write_clk);
        #1;
        check("write_address", int'(write_address), int'(e.wa));
        check("gray_write_ptr", int'(gray_write_pointer),
              int'(e.gwp));
        check("full", int'(full), int'(e.full));
        check("add_req", int'(add_req), int'(e.add));
        if (e.we)
          check("gray_one_bit",
                $countones(gray_write_pointer ^ prev_g), 1);
        prev_g = gray_write_pointer;
`ifdef ELASTIC_OVF_CNT_EN
        check("ovf_count", int'(ovf_count), e.cnt);
`endif
      end
    end
  end

  initial begin : driver
    int prob;
    logic [9:0] sym;
    bit dv;
    rst_n             = 0;
    data_valid        = 0;
    data_in           = 0;
    gray_read_pointer = 0;
    do_reset();
    do_reset();
    // Fill to full, then one dropped symbol.
    writes(17);
    step(0, 0, 10'd0);
    // SKP deletion at occupancy 12.
    do_reset();
    writes(12);
    step(0, 1, SKP_RDN);
    step(0, 1, SKP_RDP);
    step(0, 1, SKP_RDN);
    step(0, 1, rand_data());
    // Low watermark hysteresis.
    do_reset();
    writes(3);
    writes(5);
    for (int i = 0; i < 5; i++) begin
      rd_int++;
      step(0, 0, 10'd0);
    end
    writes(2);
    // Deletable SKP while full.
    do_reset();
    writes(15);
    step(0, 1, SKP_RDP);
    step(0, 1, SKP_RDN);
    step(0, 1, SKP_RDP);
    step(0, 1, rand_data());
`ifdef ELASTIC_OVF_CNT_EN
    writes(300);
`endif
    // Reset mid-stream at occupancy 9.
    do_reset();
    writes(9);
    do_reset();
    step(0, 0, 10'd0);
    // Wrap with the read pointer trailing by 4.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (wr_total >= 4) rd_int = wr_total - 4;
      step(0, 1, rand_data());
    end
    // Random traffic with varying drain rates.
    do_reset();
    for (int b = 0; b < 12; b++) begin
      prob = $urandom_range(90, 5);
      for (int i = 0; i < 150; i++) begin
        if (rd_int < wr_total && $urandom_range(99, 0) < prob)
          rd_int++;
        dv = ($urandom_range(99, 0) < 85);
        case ($urandom_range(3, 0))
          0:       sym = SKP_RDN;
          1:       sym = SKP_RDP;
          default: sym = rand_data();
        endcase
        step(0, dv, sym);
      end
    end
    step(0, 0, 10'd0);
    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(posedge write_clk);
    check("queue_drain", q.size(), 0);
    repeat (3) @(negedge write_clk);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/write_pointer_control.md
# write_pointer_control

Write-side pointer controller for the PHY receive elastic buffer, in the recovered-clock domain. It is the counterpart to the read-side controller. It accepts 10-bit symbols and generates the buffer write strobe and address, publishing a Gray-coded write pointer for the read domain. It synchronizes the read domain's Gray pointer to compute occupancy, flags full and overflow, and deletes surplus SKP symbols when the buffer runs high. It raises `add_req` when the buffer runs low so the read side can insert SKPs.

## Interface
- `DATA_WIDTH`, 10, symbol width.
- `BUFFER_DEPTH`, 16, entries, power of two; `ADDR_W = $clog2(BUFFER_DEPTH)`.
- `HIGH_WM`, 12, occupancy at or above which SKP deletion is permitted.
- `LOW_WM`, 4, occupancy at or below which `add_req` asserts.
- `write_clk`  in  1  the only clock (recovered clock); one clock domain.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `write_clk`.
- `data_in`  in  DATA_WIDTH  incoming symbol.
- `data_valid`  in  1  `data_in` is valid this cycle.
- `gray_read_pointer`  in  ADDR_W+1  read pointer, Gray coded, from the read clock domain (asynchronous).
- `write_enable`  out  1  buffer memory write strobe (combinational).
- `write_address`  out  ADDR_W+1  binary write pointer (registered); the memory uses `[ADDR_W-1:0]`.
- `gray_write_pointer`  out  ADDR_W+1  Gray of `write_address`, for the read domain.
- `full`  out  1  registered full flag.
- `skp_removed`  out  1  one-cycle pulse: a SKP was deleted this cycle (combinational).
- `add_req`  out  1  registered request for the read side to insert a SKP.
- `overflow`  out  1  one-cycle pulse: a symbol was dropped because the buffer was full (combinational).

## Operation
- **SKP symbol:** `data_in == 10'b0011111001` or `10'b1100000110`.
- **Read pointer synchronizer:** `gray_read_pointer` passes through a 2-flop synchronizer, then Gray-to-binary conversion, giving `rd_bin_s`.
- **Occupancy:** `occ = write_address - rd_bin_s`, computed modulo 2^(ADDR_W+1), range 0..BUFFER_DEPTH.
- **`skp_prev` register:** set when the last valid symbol was a SKP that was written or deleted; cleared by any valid non-SKP symbol.
- **Delete condition:** `del = data_valid & is_skp & skp_prev & (occ >= HIGH_WM)`.
  - The first SKP of each ordered set is always kept.
  - Consecutive SKPs after the first may all be deleted.
- **Write condition:** `write_enable = data_valid & ~del & ~full`. When set, `write_address` increments on the clock edge, wrapping through 2^(ADDR_W+1).
- **Overflow:** `overflow = data_valid & ~del & full`. The symbol is dropped and the pointer holds.
- **Deletion pulse:** `skp_removed = del`. A deletion takes priority over overflow, so a deletable SKP arriving while full gives `skp_removed=1`, `overflow=0`.
- **Full flag:** `full <= (occ_next == BUFFER_DEPTH)`, where `occ_next` uses the post-update write pointer and the current `rd_bin_s`.
- **`add_req` hysteresis:** set when `occ_next <= LOW_WM`; cleared when `occ_next >= (LOW_WM+HIGH_WM)/2` (8 at defaults); otherwise it holds.
- **Synchronizer pessimism:** the synchronized read pointer lags, so occupancy is overestimated. `full` may therefore assert early but never late.

## Timing
- **Reset** (`rst_n` low at a `write_clk` edge; asynchronous assertion has no effect):
  - `write_address=0`, `gray_write_pointer=0`, synchronizer flops 0, `full=0`, `add_req=0`, `skp_prev=0`, overflow count 0.
  - Combinational outputs (`write_enable`, `skp_removed`, `overflow`) are 0 while reset is held.
  - A reset in mid-stream discards the buffer contents; the read side must be reset in the same window.
- **Write latency:** a symbol with `write_enable=1` is written at edge N. `write_address` and `gray_write_pointer` show the new value after edge N.
- **Read-pointer latency:** a change on `gray_read_pointer` affects `occ` 2 edges later and `full`/`add_req` 3 edges later.
- **Wrap:** at `write_address = 2*BUFFER_DEPTH-1` the next write gives 0. Occupancy stays correct through wrap via the MSB.
- **No back-pressure:** `data_valid` is never stalled; drops are reported only through `overflow`.

## Configuration
- **`ELASTIC_OVF_CNT_EN`:**
  - Defined: adds output `ovf_count` (8 bits, registered, reset 0). It increments on each `overflow` pulse, saturates at 255, and clears only on reset.
  - Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- **Shared package `elastic_buffer_pkg`:**
  - `SKP_RDN = 10'b0011111001`, `SKP_RDP = 10'b1100000110`.
  - The default `DATA_WIDTH`, `BUFFER_DEPTH`, `HIGH_WM` and `LOW_WM`.
  - The read side uses the same SKP constants.
- **Sub-modules:**
  - Reuse the existing `binToGray` (width ADDR_W+1) for `gray_write_pointer`.
  - Add one new sub-module, `grayToBin`, parameterized by width, for the synchronized read pointer.

## Test plan
- **Reset:** apply reset, then stream 16 non-SKP symbols with `gray_read_pointer` held at 0. Required: `write_address` 0→16; `full=1` after edge 16; the 17th symbol gives `overflow=1` and the pointer holds at 16.
- **SKP deletion:** hold occupancy at 12 (read pointer static), then send SKP, SKP, SKP. Required: first SKP written (occupancy 13); second and third deleted with `skp_removed=1`; `write_address` increases by 1 only.
- **Low threshold:** with occupancy at 3 and the read pointer advancing, required `add_req=1`. Raise occupancy to 8: `add_req` clears. At occupancies 5–7 it holds its previous value.
- **Wrap:** drive 40 writes with the read pointer trailing by 4 (Gray). Required: `write_address` wraps 31→0; `full` never asserts; `gray_write_pointer` changes exactly one bit per write.
- **Full with deletable SKP:** with `full=1`, `skp_prev=1` and a SKP arriving, required `skp_removed=1`, `overflow=0`. With `ELASTIC_OVF_CNT_EN` defined, 300 forced overflows give `ovf_count=255`.
- **Reset mid-stream:** assert `rst_n=0` at occupancy 9. Required after the next edge: all registered outputs are 0, including `write_address` and `full`.
